// File: rtl/egress_switch_pkg.sv
// Shared definitions for the egress crossbar: port geometry, AXI-Stream
// beat views and the per-output arbitration state.
package egress_switch_pkg;

  localparam int NUM_INGRESS_PORTS  = 4;
  localparam int AXIS_DATA_WIDTH    = 16;
  localparam int AXIS_DEST_WIDTH    = 2;
  localparam int FRAME_COUNT_WIDTH  = 32;

  // Forward (source-driven) half of one AXI-Stream link.
  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic                       tvalid;
    logic                       tlast;
    logic [AXIS_DEST_WIDTH-1:0] tdest;
  } axis_d_source_t;

  // Backward (sink-driven) half of one AXI-Stream link.
  typedef struct packed {
    logic tready;
  } axis_d_sink_t;

  // Per-output state: IDLE arbitrates, LOCKED forwards one frame.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } egress_state_e;

endpackage

// File: rtl/egress_switch_rr_arbiter.sv
// Round-robin picker: returns the first asserted request found when scanning
// upward from ptr, wrapping modulo N. Purely combinational.
module rr_arbiter
  import egress_switch_pkg::*;
#(
  parameter int N = NUM_INGRESS_PORTS,
  parameter int W = AXIS_DEST_WIDTH
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);

  logic [W-1:0] cand;

  // Scan ptr, ptr+1, ... and keep the first requester; W-bit add wraps.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + W'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/egress_switch.sv
// Frame-granular NxN AXI-Stream crossbar. Each output locks onto one input
// from its first beat to tlast, chosen round-robin among inputs whose tdest
// names that output. out_tdest reports the source input of the frame.
//
// Handshake: a beat moves on output o when out_tvalid[o] && out_tready[o];
// while o is LOCKED to input g, in_tready[g] mirrors out_tready[o] and the
// same cycle consumes the input beat. Unlocked inputs see in_tready = 0.
module egress_switch
  import egress_switch_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_INGRESS_PORTS,
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int DEST_WIDTH = AXIS_DEST_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   in_tdata,
  input  logic [NUM_PORTS-1:0]              in_tvalid,
  input  logic [NUM_PORTS-1:0]              in_tlast,
  input  logic [NUM_PORTS*DEST_WIDTH-1:0]   in_tdest,
  output logic [NUM_PORTS-1:0]              in_tready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   out_tdata,
  output logic [NUM_PORTS-1:0]              out_tvalid,
  output logic [NUM_PORTS-1:0]              out_tlast,
  output logic [NUM_PORTS*DEST_WIDTH-1:0]   out_tdest,
  input  logic [NUM_PORTS-1:0]              out_tready,
  output logic [NUM_PORTS-1:0]              out_busy,
  output logic [NUM_PORTS*FRAME_COUNT_WIDTH-1:0] out_frames
);

  localparam int CW = FRAME_COUNT_WIDTH;

  egress_state_e         state_q  [NUM_PORTS];
  egress_state_e         state_d  [NUM_PORTS];
  logic [DEST_WIDTH-1:0] g_q      [NUM_PORTS];
  logic [DEST_WIDTH-1:0] g_d      [NUM_PORTS];
  logic [DEST_WIDTH-1:0] p_q      [NUM_PORTS];
  logic [DEST_WIDTH-1:0] p_d      [NUM_PORTS];
  logic [CW-1:0]         frames_q [NUM_PORTS];
  logic [CW-1:0]         frames_d [NUM_PORTS];

  logic [NUM_PORTS-1:0]  input_locked;
  logic [NUM_PORTS-1:0]  req [NUM_PORTS];
  logic [NUM_PORTS-1:0]  arb_valid;
  logic [DEST_WIDTH-1:0] arb_idx [NUM_PORTS];
  int                    sel;

  // Inputs already owned by some LOCKED output must not request again.
  always_comb begin
    input_locked = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == LOCKED) input_locked[g_q[o]] = 1'b1;
    end
  end

  // Request matrix: req[o][i] is set when free input i targets output o.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = in_tvalid[i] && !input_locked[i] &&
                    (in_tdest[i*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter #(.N(NUM_PORTS), .W(DEST_WIDTH)) u_arb (
      .req        (req[o]),
      .ptr        (p_q[o]),
      .grant_valid(arb_valid[o]),
      .grant_idx  (arb_idx[o])
    );
  end

  // Output muxes and ready steering; idle outputs drive all zeros.
  always_comb begin
    out_tdata  = '0;
    out_tvalid = '0;
    out_tlast  = '0;
    out_tdest  = '0;
    out_busy   = '0;
    out_frames = '0;
    in_tready  = '0;
    sel        = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_frames[o*CW +: CW] = frames_q[o];
      if (state_q[o] == LOCKED) begin
        sel = int'(g_q[o]);
        out_tdata[o*DATA_WIDTH +: DATA_WIDTH] = in_tdata[sel*DATA_WIDTH +: DATA_WIDTH];
        out_tvalid[o]                         = in_tvalid[sel];
        out_tlast[o]                          = in_tlast[sel];
        out_tdest[o*DEST_WIDTH +: DEST_WIDTH] = g_q[o];
        out_busy[o]                           = 1'b1;
        in_tready[sel]                        = out_tready[o];
      end
    end
  end

  // Per-output next state: lock on a grant, release after the tlast beat.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o]  = state_q[o];
      g_d[o]      = g_q[o];
      p_d[o]      = p_q[o];
      frames_d[o] = frames_q[o];
      case (state_q[o])
        IDLE: begin
          if (arb_valid[o]) begin
            g_d[o]     = arb_idx[o];
            state_d[o] = LOCKED;
          end
        end
        LOCKED: begin
          if (out_tvalid[o] && out_tready[o] && out_tlast[o]) begin
            state_d[o]  = IDLE;
            p_d[o]      = g_q[o] + DEST_WIDTH'(1);
            frames_d[o] = frames_q[o] + CW'(1);
          end
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (reset) begin
        state_q[o]  <= IDLE;
        g_q[o]      <= '0;
        p_q[o]      <= '0;
        frames_q[o] <= '0;
      end else begin
        state_q[o]  <= state_d[o];
        g_q[o]      <= g_d[o];
        p_q[o]      <= p_d[o];
        frames_q[o] <= frames_d[o];
      end
    end
  end

endmodule

// File: tb/tb_egress_switch.sv
// Bench for egress_switch: per-input beat queues drive frames, a
// frame-ownership model predicts every output each cycle, and directed
// scenarios pin the model with literal expectations.
module tb_egress_switch;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int TW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP*DW-1:0] in_tdata;
  logic [NP-1:0]    in_tvalid, in_tlast, in_tready;
  logic [NP*TW-1:0] in_tdest;
  logic [NP*DW-1:0] out_tdata;
  logic [NP-1:0]    out_tvalid, out_tlast, out_tready, out_busy;
  logic [NP*TW-1:0] out_tdest;
  logic [NP*32-1:0] out_frames;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  egress_switch #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .DEST_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tdest(in_tdest), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tdest(out_tdest), .out_tready(out_tready),
    .out_busy(out_busy), .out_frames(out_frames)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [TW-1:0] dest;
    int            gap;
  } beat_t;

  beat_t         src_q [NP][$];
  int            gap_left [NP];
  logic [NP-1:0] acc_g;
  int            ready_mode, ready_pct, cyc;
  int            checks, failures;

  // model: owner = source input locked to each output, -1 when free
  int            owner [NP], ptr [NP];
  logic [31:0]   cnt [NP];
  int            n_owner [NP], n_ptr [NP];
  logic [31:0]   n_cnt [NP];

  // observation logs
  int            start_log[$];
  int            arb_cyc[$];
  int            first_xfer [NP];
  int            beats_seen [NP];
  int            mon_out;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h expected=%0h cycle=%0d", name, idx, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_beat(input int i, input logic [DW-1:0] d, input logic l,
                           input logic [TW-1:0] dst, input int gap);
    beat_t b;
    b.data = d; b.last = l; b.dest = dst; b.gap = gap;
    if (src_q[i].size() == 0) gap_left[i] = gap;
    src_q[i].push_back(b);
  endtask

  task automatic push_frame(input int i, input logic [DW-1:0] base, input int len,
                            input logic [TW-1:0] dst);
    for (int k = 0; k < len; k++) push_beat(i, base + DW'(k), k == len - 1, dst, 0);
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0 && gap_left[i] == 0) begin
        in_tvalid[i]          = 1'b1;
        in_tdata[i*DW +: DW]  = src_q[i][0].data;
        in_tlast[i]           = src_q[i][0].last;
        in_tdest[i*TW +: TW]  = src_q[i][0].dest;
      end else begin
        in_tvalid[i]          = 1'b0;
        in_tdata[i*DW +: DW]  = '0;
        in_tlast[i]           = 1'b0;
        in_tdest[i*TW +: TW]  = '0;
      end
      case (ready_mode)
        1:       out_tready[i] = ($urandom_range(99) < ready_pct);
        2:       out_tready[i] = (cyc % 2 == 0);
        default: out_tready[i] = 1'b1;
      endcase
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      owner[o] = -1; ptr[o] = 0; cnt[o] = 0;
      first_xfer[o] = -1; beats_seen[o] = 0;
    end
    start_log.delete();
    arb_cyc.delete();
  endtask

  // ---------------- model + per-cycle compare ----------------
  task automatic model_step();
    logic [NP-1:0] locked, exp_rdy;
    logic          ev, el, eb;
    logic [DW-1:0] ed;
    logic [TW-1:0] edst;
    int            s, i;
    locked = '0; exp_rdy = '0;
    for (int o = 0; o < NP; o++) if (owner[o] >= 0) locked[owner[o]] = 1'b1;
    for (int o = 0; o < NP; o++) begin
      s = owner[o];
      ev = 0; el = 0; eb = 0; ed = '0; edst = '0;
      if (s >= 0) begin
        ev = in_tvalid[s]; ed = in_tdata[s*DW +: DW]; el = in_tlast[s];
        edst = TW'(s); eb = 1'b1; exp_rdy[s] = out_tready[o];
      end
      check("out_tvalid", o, out_tvalid[o], ev);
      check("out_tdata",  o, out_tdata[o*DW +: DW], ed);
      check("out_tlast",  o, out_tlast[o], el);
      check("out_tdest",  o, out_tdest[o*TW +: TW], edst);
      check("out_busy",   o, out_busy[o], eb);
      check("out_frames", o, out_frames[o*32 +: 32], cnt[o]);
      if (o == mon_out && out_tvalid[o] && out_tready[o] && exp_q.size() > 0)
        check("sb_data", o, out_tdata[o*DW +: DW], exp_q.pop_front());
    end
    check("in_tready", 0, in_tready, exp_rdy);

    for (int o = 0; o < NP; o++) begin
      n_owner[o] = owner[o]; n_ptr[o] = ptr[o]; n_cnt[o] = cnt[o];
      if (owner[o] < 0) begin
        for (int k = 0; k < NP; k++) begin
          i = (ptr[o] + k) % NP;
          if (n_owner[o] < 0 && in_tvalid[i] && !locked[i] &&
              in_tdest[i*TW +: TW] == TW'(o)) begin
            n_owner[o] = i;
            start_log.push_back(o * 10 + i);
            arb_cyc.push_back(cyc);
          end
        end
      end else begin
        s = owner[o];
        if (in_tvalid[s] && out_tready[o]) begin
          beats_seen[o]++;
          if (first_xfer[o] < 0) first_xfer[o] = cyc;
          if (in_tlast[s]) begin
            n_owner[o] = -1;
            n_ptr[o]   = (s + 1) % NP;
            n_cnt[o]   = cnt[o] + 32'd1;
          end
        end
      end
      if (reset) begin
        n_owner[o] = -1; n_ptr[o] = 0; n_cnt[o] = '0;
      end
    end
    acc_g = in_tvalid & exp_rdy;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int o = 0; o < NP; o++) begin
      owner[o] = n_owner[o]; ptr[o] = n_ptr[o]; cnt[o] = n_cnt[o];
    end
    for (int i = 0; i < NP; i++) begin
      if (gap_left[i] > 0) gap_left[i]--;
      else if (acc_g[i]) begin
        void'(src_q[i].pop_front());
        gap_left[i] = (src_q[i].size() > 0) ? src_q[i][0].gap : 0;
      end
    end
    cyc++;
  endtask

  function automatic logic pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < NP; i++) if (src_q[i].size() > 0 || owner[i] >= 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (pending() && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_done", 0, pending(), 1'b0);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NP; i++) begin
      src_q[i].delete();
      gap_left[i] = 0;
    end
  endtask

  task automatic raw_reset();
    reset = 1'b1;
    in_tvalid = '0; in_tdata = '0; in_tlast = '0; in_tdest = '0; out_tready = '1;
    clear_sources();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    mon_out = -1;
    exp_q.delete();
    check("rst_tvalid", 0, out_tvalid, '0);
    check("rst_tready", 0, in_tready, '0);
    check("rst_busy",   0, out_busy, '0);
    for (int o = 0; o < NP; o++) check("rst_frames", o, out_frames[o*32 +: 32], '0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int t0, total, nframes, len;
    int e2 [3];
    checks = 0; failures = 0; cyc = 0; ready_mode = 0; ready_pct = 70;
    acc_g = '0;

    // single 4-beat frame, input 0 -> output 2
    raw_reset();
    t0 = cyc;
    push_frame(0, 16'hA000, 4, 2'd2);
    drain(40);
    check("t1_latency", 2, first_xfer[2] - t0, 1);
    check("t1_beats",   2, beats_seen[2], 4);
    check("t1_frames",  2, out_frames[2*32 +: 32], 1);
    check("t1_src",     0, (start_log.size() == 1) ? start_log[0] : -1, 20);

    // inputs 0,1,3 contend for output 1
    raw_reset();
    push_frame(0, 16'h1000, 2, 2'd1);
    push_frame(1, 16'h1100, 2, 2'd1);
    push_frame(3, 16'h1300, 2, 2'd1);
    drain(60);
    e2 = '{10, 11, 13};
    for (int k = 0; k < 3; k++)
      check("t2_order", k, (start_log.size() > k) ? start_log[k] : -1, e2[k]);
    for (int k = 0; k < 2; k++)
      check("t2_spacing", k, (arb_cyc.size() > k + 1) ? arb_cyc[k+1] - arb_cyc[k] : -1, 3);
    check("t2_frames", 1, out_frames[1*32 +: 32], 3);
    check("t2_ptr",    1, ptr[1], 0);

    // all four outputs in parallel
    raw_reset();
    t0 = cyc;
    for (int i = 0; i < NP; i++) push_frame(i, 16'h2000 + DW'(i * 256), 2, TW'(3 - i));
    drain(40);
    for (int o = 0; o < NP; o++) begin
      check("t3_latency", o, first_xfer[o] - t0, 1);
      check("t3_frames",  o, out_frames[o*32 +: 32], 1);
    end

    // toggling out_tready plus a 2-cycle tvalid drop mid-frame
    raw_reset();
    ready_mode = 2;
    mon_out = 0;
    for (int k = 0; k < 6; k++) begin
      push_beat(1, 16'h3000 + DW'(k), k == 5, 2'd0, (k == 3) ? 2 : 0);
      exp_q.push_back(16'h3000 + DW'(k));
    end
    drain(80);
    check("t4_leftover", 0, exp_q.size(), 0);
    check("t4_beats",    0, beats_seen[0], 6);
    check("t4_frames",   0, out_frames[0 +: 32], 1);
    ready_mode = 0;
    mon_out = -1;

    // tdest changes after the first beat
    raw_reset();
    push_beat(2, 16'h4000, 1'b0, 2'd0, 0);
    push_beat(2, 16'h4001, 1'b0, 2'd3, 0);
    push_beat(2, 16'h4002, 1'b1, 2'd3, 0);
    push_frame(2, 16'h4100, 2, 2'd3);
    drain(40);
    check("t5_frames0", 0, out_frames[0*32 +: 32], 1);
    check("t5_frames3", 3, out_frames[3*32 +: 32], 1);
    check("t5_first",   0, (start_log.size() > 0) ? start_log[0] : -1, 2);
    check("t5_second",  0, (start_log.size() > 1) ? start_log[1] : -1, 32);

    // reset in the middle of a frame on output 1
    raw_reset();
    push_beat(2, 16'h5000, 1'b1, 2'd1, 0);
    push_beat(0, 16'h5100, 1'b0, 2'd1, 4);
    for (int k = 1; k < 6; k++) push_beat(0, 16'h5100 + DW'(k), k == 5, 2'd1, 0);
    repeat (7) step();
    check("t6_pre_frames", 1, out_frames[1*32 +: 32], 1);
    check("t6_pre_busy",   1, out_busy[1], 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_sources();
    check("t6_rst_tvalid", 0, out_tvalid, '0);
    check("t6_rst_tready", 0, in_tready, '0);
    check("t6_rst_busy",   0, out_busy, '0);
    check("t6_rst_frames", 1, out_frames[1*32 +: 32], '0);
    start_log.delete();
    push_frame(0, 16'h5200, 2, 2'd1);
    push_frame(3, 16'h5300, 2, 2'd1);
    drain(40);
    check("t6_first",  0, (start_log.size() > 0) ? start_log[0] : -1, 10);
    check("t6_second", 0, (start_log.size() > 1) ? start_log[1] : -1, 13);
    check("t6_frames", 1, out_frames[1*32 +: 32], 2);

    // randomized traffic with gaps, backpressure and mid-frame tdest noise
    raw_reset();
    ready_mode = 1;
    nframes = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (src_q[i].size() < 2 && $urandom_range(3) == 0) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++)
            push_beat(i, DW'((i << 12) | ((nframes * 4 + k) & 12'hfff)), k == len - 1,
                      TW'($urandom_range(NP - 1)),
                      ($urandom_range(3) == 0) ? $urandom_range(1, 2) : 0);
          nframes++;
        end
      end
      step();
    end
    ready_mode = 0;
    drain(300);
    total = 0;
    for (int o = 0; o < NP; o++) total += int'(out_frames[o*32 +: 32]);
    check("t7_total_frames", 0, total, nframes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
